// File: rtl/subword_mem_ctrl_pkg.sv
// Shared definitions for the sub-word load/store sequencer: access-size and
// FSM state encodings plus the alignment rule used when a request is accepted.
package subword_mem_ctrl_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_RESP = 2'b11
   } state_e;

   // A half needs an even address, a word needs a 4-byte boundary, and the
   // reserved size code is always rejected, so it shares the misalign path.
   function automatic logic isMisaligned(input size_e size, input logic [1:0] lane);
      logic bad;
      bad = 1'b0;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = lane[0];
         SIZE_WORD: bad = (lane != 2'b00);
         SIZE_ILL:  bad = 1'b1;
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/subword_mem_ctrl_lane_extend.sv
// Load lane extractor: picks the addressed byte or half out of a full memory
// word (little-endian lanes) and sign- or zero-extends it to 32 bits.
module subword_mem_ctrl_lane_extend
   import subword_mem_ctrl_pkg::*;
(
   input  logic [DATA_W-1:0] word_i,
   input  logic [1:0]        lane_i,
   input  size_e             size_i,
   input  logic              unsigned_i,
   output logic [DATA_W-1:0] result_o
);

   logic [7:0]  laneByte;
   logic [15:0] laneHalf;

   // Select the lane first, then replicate its top bit unless zero-extending.
   always_comb begin
      laneByte = word_i[{lane_i, 3'b000} +: 8];
      laneHalf = word_i[{lane_i[1], 4'b0000} +: 16];
      result_o = word_i;
      case (size_i)
         SIZE_BYTE: result_o = {{24{laneByte[7] & ~unsigned_i}}, laneByte};
         SIZE_HALF: result_o = {{16{laneHalf[15] & ~unsigned_i}}, laneHalf};
         default:   result_o = word_i;
      endcase
   end

endmodule

// File: rtl/subword_mem_ctrl.sv
// Load/store sequencer between the MEM stage and a 32-bit word-addressed
// memory. One request is in flight at a time; sub-word stores are done as a
// read-modify-write of the containing word, misaligned requests never touch
// memory, and a stalled memory is abandoned after ACK_TIMEOUT cycles.
module subword_mem_ctrl
   import subword_mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_misalign,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int unsigned      CNT_W      = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = (ACK_TIMEOUT == 0) ? '0 : CNT_W'(ACK_TIMEOUT - 1);
   localparam logic             TIMEOUT_EN = (ACK_TIMEOUT != 0);

   state_e              state_q, state_d;
   logic                isStore_q, isStore_d;
   size_e               size_q, size_d;
   logic                isUnsigned_q, isUnsigned_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                misalign_q, misalign_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    waitCnt_q, waitCnt_d;

   logic [DATA_W-1:0]   loadResult;
   logic [DATA_W-1:0]   mergedWord;
   logic                timeoutHit;
   size_e               reqSize;

   assign reqSize    = size_e'(req_size);
   assign timeoutHit = TIMEOUT_EN && (waitCnt_q == CNT_LAST);

   subword_mem_ctrl_lane_extend u_laneExtend (
      .word_i     (mem_rdata),
      .lane_i     (addr_q[1:0]),
      .size_i     (size_q),
      .unsigned_i (isUnsigned_q),
      .result_o   (loadResult)
   );

   // Store merge: drop the new byte/half into the word just read, keeping the
   // other lanes; a full-word store simply takes the request data.
   always_comb begin
      mergedWord = mem_rdata;
      case (size_q)
         SIZE_BYTE: mergedWord[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
         SIZE_HALF: mergedWord[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default:   mergedWord = wdata_q;
      endcase
   end

   // Sequencer next state: accept in IDLE, read and/or write memory, then
   // present the response for exactly one cycle.
   always_comb begin
      state_d      = state_q;
      isStore_d    = isStore_q;
      size_d       = size_q;
      isUnsigned_d = isUnsigned_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      misalign_d   = misalign_q;
      err_d        = err_q;
      waitCnt_d    = waitCnt_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               isStore_d    = req_we;
               size_d       = reqSize;
               isUnsigned_d = req_unsigned;
               addr_d       = req_addr;
               wdata_d      = req_wdata;
               rdata_d      = '0;
               misalign_d   = 1'b0;
               err_d        = 1'b0;
               waitCnt_d    = '0;
               if (isMisaligned(reqSize, req_addr[1:0])) begin
                  misalign_d = 1'b1;
                  state_d    = ST_RESP;
               end else if (req_we && (reqSize == SIZE_WORD)) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end
         end

         ST_RD: begin
            if (mem_ack) begin
               if (isStore_q) begin
                  wdata_d   = mergedWord;
                  waitCnt_d = '0;
                  state_d   = ST_WR;
               end else begin
                  rdata_d = loadResult;
                  state_d = ST_RESP;
               end
            end else if (timeoutHit) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               waitCnt_d = waitCnt_q + CNT_W'(1);
            end
         end

         ST_WR: begin
            if (mem_ack) begin
               state_d = ST_RESP;
            end else if (timeoutHit) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               waitCnt_d = waitCnt_q + CNT_W'(1);
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and latched-request registers; reset abandons any access in flight.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         isStore_q    <= 1'b0;
         size_q       <= SIZE_BYTE;
         isUnsigned_q <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         misalign_q   <= 1'b0;
         err_q        <= 1'b0;
         waitCnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         isStore_q    <= isStore_d;
         size_q       <= size_d;
         isUnsigned_q <= isUnsigned_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         misalign_q   <= misalign_d;
         err_q        <= err_d;
         waitCnt_q    <= waitCnt_d;
      end
   end

   assign req_ready    = (state_q == ST_IDLE);
   assign rsp_valid    = (state_q == ST_RESP);
   assign rsp_rdata    = rsp_valid ? rdata_q : '0;
   assign rsp_misalign = rsp_valid & misalign_q;
   assign rsp_err      = rsp_valid & err_q;
   assign mem_en       = (state_q == ST_RD) || (state_q == ST_WR);
   assign mem_we       = (state_q == ST_WR);
   assign mem_addr     = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata    = mem_we ? wdata_q : '0;

endmodule
